// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback <-> scoreboard signal bundle
// master: decode/writeback side (drives issue/wb/flush, reads stall/issue_fire/busy/err)
// slave:  scoreboard side
interface reg_scoreboard_if;
  logic       issue_valid;
  logic [2:0] issue_rd;
  logic       issue_ws;
  logic [2:0] src1;
  logic [2:0] src2;
  logic       src1_use;
  logic       src2_use;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic [7:0] busy;
  logic       err;
  modport master (
    output issue_valid, issue_rd, issue_ws, src1, src2, src1_use, src2_use, wb_valid, wb_rd, flush,
    input  stall, issue_fire, busy, err
  );
  modport slave (
    input  issue_valid, issue_rd, issue_ws, src1, src2, src1_use, src2_use, wb_valid, wb_rd, flush,
    output stall, issue_fire, busy, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters that stall issue on RAW and saturation hazards
// ports: clk, rst_n (async active-low), sb (reg_scoreboard_if.slave: issue/src/wb/flush in, stall/issue_fire/busy/err out)
// optional: WB_BYPASS_EN lets a source issue in the same cycle as its last outstanding writeback
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  reg_scoreboard_if.slave  sb
);
  logic [7:0][CNT_W-1:0] cnt;
  logic [7:0] nz, inc, dec;
  logic byp1, byp2, haz1, haz2, sat, fire;
  for (genvar i = 0; i < 8; i++) begin : g_reg
    assign nz[i]  = |cnt[i];
    assign inc[i] = fire & sb.issue_ws & (sb.issue_rd == 3'(i));
    assign dec[i] = sb.wb_valid & (sb.wb_rd == 3'(i)) & nz[i];
  end
`ifdef WB_BYPASS_EN
  // the writeback retires the only outstanding write, so forwarded data is final
  assign byp1 = sb.wb_valid & (sb.wb_rd == sb.src1) & (cnt[sb.src1] == CNT_W'(1));
  assign byp2 = sb.wb_valid & (sb.wb_rd == sb.src2) & (cnt[sb.src2] == CNT_W'(1));
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  // sources see pre-issue counts, so an instruction never stalls on its own write
  assign haz1          = sb.src1_use & nz[sb.src1] & ~byp1;
  assign haz2          = sb.src2_use & nz[sb.src2] & ~byp2;
  assign sat           = sb.issue_ws & (&cnt[sb.issue_rd]);
  assign sb.stall      = sb.issue_valid & (haz1 | haz2 | sat);
  assign fire          = sb.issue_valid & ~sb.stall;
  assign sb.issue_fire = fire;
  assign sb.busy       = nz;
  // simultaneous inc and dec cancel; dec is already gated off at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (sb.flush) cnt <= '0;
    else for (int i = 0; i < 8; i++) cnt[i] <= cnt[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sb.err <= 1'b0;
    else if (sb.wb_valid & ~nz[sb.wb_rd]) sb.err <= 1'b1;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table, hand sequences and randomized model check for reg_scoreboard
module tb_reg_scoreboard;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {
    logic v; logic [2:0] rd; logic ws;
    logic [2:0] s1; logic u1; logic [2:0] s2; logic u2;
    logic wv; logic [2:0] wrd; logic fl;
    logic es; logic ef; logic [7:0] eb; logic ee;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt_m [8];
  bit err_m;
  vec_t tbl [$];
  reg_scoreboard_if sbi ();
  reg_scoreboard #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .sb(sbi));
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic v, input logic [2:0] rd, input logic ws, input logic [2:0] s1, input logic u1,
                              input logic [2:0] s2, input logic u2, input logic wv, input logic [2:0] wrd, input logic fl,
                              input logic es, input logic ef, input logic [7:0] eb, input logic ee);
    vec_t t;
    t.v = v; t.rd = rd; t.ws = ws; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2;
    t.wv = wv; t.wrd = wrd; t.fl = fl; t.es = es; t.ef = ef; t.eb = eb; t.ee = ee;
    return t;
  endfunction
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    sbi.issue_valid = t.v; sbi.issue_rd = t.rd; sbi.issue_ws = t.ws;
    sbi.src1 = t.s1; sbi.src1_use = t.u1; sbi.src2 = t.s2; sbi.src2_use = t.u2;
    sbi.wb_valid = t.wv; sbi.wb_rd = t.wrd; sbi.flush = t.fl;
  endtask
  function automatic bit m_stall();
    bit h1, h2, sat;
    h1 = sbi.src1_use && cnt_m[sbi.src1] != 0 && !(BYP && sbi.wb_valid && sbi.wb_rd == sbi.src1 && cnt_m[sbi.src1] == 1);
    h2 = sbi.src2_use && cnt_m[sbi.src2] != 0 && !(BYP && sbi.wb_valid && sbi.wb_rd == sbi.src2 && cnt_m[sbi.src2] == 1);
    sat = sbi.issue_ws && cnt_m[sbi.issue_rd] == CMAX;
    return sbi.issue_valid && (h1 || h2 || sat);
  endfunction
  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cnt_m[i] != 0;
    return b;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    err_m = 0;
  endtask
  task automatic tick();
    int nxt [8];
    bit fire;
    fire = sbi.issue_valid && !m_stall();
    for (int i = 0; i < 8; i++)
      nxt[i] = sbi.flush ? 0 : cnt_m[i] + int'(fire && sbi.issue_ws && sbi.issue_rd == i) - int'(sbi.wb_valid && sbi.wb_rd == i && cnt_m[i] > 0);
    if (sbi.wb_valid && cnt_m[sbi.wb_rd] == 0) err_m = 1;
    @(posedge clk);
    cnt_m = nxt;
    @(negedge clk);
  endtask
  task automatic check_model(input string tag);
    bit s;
    s = m_stall();
    check({tag, "_stall"}, 8'(sbi.stall), 8'(s));
    check({tag, "_fire"}, 8'(sbi.issue_fire), 8'(sbi.issue_valid && !s));
    check({tag, "_busy"}, sbi.busy, m_busy());
    check({tag, "_err"}, 8'(sbi.err), 8'(err_m));
  endtask
  initial begin
    vec_t r;
    m_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    // reset ADD/RAW/saturation/simultaneous/underflow/fill/flush sequence
    tbl.push_back(mk(1,3,1,0,0,0,0,0,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h08,0));
    tbl.push_back(mk(1,1,0,3,1,0,0,0,0,0, 1,0,8'h08,0));
    tbl.push_back(mk(1,1,0,3,1,0,0,1,3,0, !BYP,BYP,8'h08,0));
    tbl.push_back(mk(1,1,0,3,1,0,0,0,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0, 0,1,8'h00,0));
    tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0, 0,1,8'h20,0));
    tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0, 0,1,8'h20,0));
    tbl.push_back(mk(1,5,1,0,0,0,0,1,5,0, 1,0,8'h20,0));
    tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0, 0,1,8'h20,0));
    tbl.push_back(mk(1,2,1,0,0,0,0,0,0,0, 0,1,8'h20,0));
    tbl.push_back(mk(1,2,1,0,0,0,0,1,2,0, 0,1,8'h24,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h24,0));
    tbl.push_back(mk(1,4,1,4,1,4,1,0,0,0, 0,1,8'h24,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,6,0, 0,0,8'h34,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h34,1));
    tbl.push_back(mk(1,0,1,0,0,0,0,0,0,0, 0,1,8'h34,1));
    tbl.push_back(mk(1,1,1,0,0,0,0,0,0,0, 0,1,8'h35,1));
    tbl.push_back(mk(1,3,1,0,0,0,0,0,0,0, 0,1,8'h37,1));
    tbl.push_back(mk(1,6,1,0,0,0,0,0,0,0, 0,1,8'h3F,1));
    tbl.push_back(mk(1,7,1,0,0,0,0,0,0,0, 0,1,8'h7F,1));
    tbl.push_back(mk(1,1,1,0,0,0,0,0,0,1, 0,1,8'hFF,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,1));
    tbl.push_back(mk(1,1,1,0,0,0,0,0,0,0, 0,1,8'h00,1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", sbi.busy, 8'h00);
    check("rst_err", 8'(sbi.err), 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      #1;
      check($sformatf("v%0d_stall", k), 8'(sbi.stall), 8'(tbl[k].es));
      check($sformatf("v%0d_fire", k), 8'(sbi.issue_fire), 8'(tbl[k].ef));
      check($sformatf("v%0d_busy", k), sbi.busy, tbl[k].eb);
      check($sformatf("v%0d_err", k), 8'(sbi.err), 8'(tbl[k].ee));
      tick();
    end
    // cnt[1]=1 here: dependent read stalls, then reset drops mid-cycle
    drive(mk(1,0,0,1,1,0,0,0,0,0, 0,0,0,0));
    #1;
    check("pre_rst_stall", 8'(sbi.stall), 8'h01);
    check("pre_rst_busy", sbi.busy, 8'h02);
    #1 rst_n = 1'b0;
    #1;
    m_reset();
    check("async_rst_busy", sbi.busy, 8'h00);
    check("async_rst_err", 8'(sbi.err), 8'h00);
    check("async_rst_stall", 8'(sbi.stall), 8'h00);
    check("async_rst_fire", 8'(sbi.issue_fire), 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 600; k++) begin
      r = mk(1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
             1'($urandom_range(0, 2) == 0), 3'($urandom), 1'($urandom_range(0, 40) == 0), 0, 0, 0, 0);
      drive(r);
      #1;
      check_model($sformatf("rnd%0d", k));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
